ps2_arrow_key_tracker: RTL and testbench

- Sequences the raw byte stream from the PS/2 controller (`received_data`/`received_data_en`) into complete make/break key events.
- Decodes the E0 (extended) and F0 (break) prefixes and keeps the held state of the right, left and up arrow keys.
- Resolves left/right conflicts by last-pressed priority and generates a one-cycle jump pulse.
- Sits between PS2_Controller and the game/motion logic; `last_code` feeds the existing hex display path.

---
 rtl/ps2_arrow_key_tracker.sv | 160 ++++++++++++++++
 tb/tb_ps2_arrow_key_tracker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_key_tracker.sv
// Turns the PS/2 byte stream into make/break key events and tracks the
// held state of the right, left and up arrow keys.
module ps2_arrow_key_tracker #(
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter bit          REQUIRE_EXT = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic       held_right,
  output logic       held_left,
  output logic       held_up,
  output logic       dir_right,
  output logic       dir_left,
  output logic       jump_pulse,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic [7:0] last_code,
  output logic       err_timeout
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;
  typedef enum logic [1:0] {LH_NONE, LH_RIGHT, LH_LEFT} lh_t;

  state_t        state, state_n;
  lh_t           last_h, last_h_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          is_e0, is_f0, ignored;
  logic          fire, fire_brk, fire_ext, timeout;
  logic          arrow_ok, is_r, is_l, is_u;
  logic          hr_n, hl_n, hu_n, dr_n, dl_n, jump_n;

  assign is_e0 = (rx_data == 8'hE0);
  assign is_f0 = (rx_data == 8'hF0);

  always_comb begin
    ignored = 1'b0;
    case (rx_data)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h00, 8'hFF: ignored = 1'b1;
      default: ignored = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)    state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fire     = 1'b0;
    fire_brk = 1'b0;
    fire_ext = 1'b0;
    timeout  = 1'b0;
    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_e0)        state_n = S_EXT;
          else if (is_f0)   state_n = S_BRK;
          else if (!ignored) fire   = 1'b1;
        end
        S_EXT: begin
          if (is_f0)       state_n = S_EXT_BRK;
          else if (!is_e0) begin
            fire     = 1'b1;
            fire_ext = 1'b1;
            state_n  = S_IDLE;
          end
        end
        S_BRK: begin
          if (is_e0)       state_n = S_EXT;
          else if (!is_f0) begin
            fire     = 1'b1;
            fire_brk = 1'b1;
            state_n  = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (!is_e0 && !is_f0) begin
            fire     = 1'b1;
            fire_brk = 1'b1;
            fire_ext = 1'b1;
            state_n  = S_IDLE;
          end
        end
      endcase
    end else if (state != S_IDLE && cnt == CNT_MAX) begin
      timeout = 1'b1;
      state_n = S_IDLE;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    cnt_n = '0;
    if (!rx_valid && state != S_IDLE && !timeout) cnt_n = cnt + 1'b1;
  end

  always_comb begin
    arrow_ok = fire && (!REQUIRE_EXT || fire_ext);
    is_r     = arrow_ok && (rx_data == 8'h74);
    is_l     = arrow_ok && (rx_data == 8'h6B);
    is_u     = arrow_ok && (rx_data == 8'h75);
    hr_n     = is_r ? !fire_brk : held_right;
    hl_n     = is_l ? !fire_brk : held_left;
    hu_n     = is_u ? !fire_brk : held_up;
    jump_n   = is_u && !fire_brk && !held_up;
    // Only a fresh press (not typematic repeat) claims horizontal priority.
    last_h_n = last_h;
    if (is_r && !fire_brk && !held_right)     last_h_n = LH_RIGHT;
    else if (is_l && !fire_brk && !held_left) last_h_n = LH_LEFT;
    dr_n = hr_n && (!hl_n || last_h_n == LH_RIGHT);
    dl_n = hl_n && (!hr_n || last_h_n == LH_LEFT);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn || clear) begin
      cnt         <= '0;
      last_h      <= LH_NONE;
      held_right  <= 1'b0;
      held_left   <= 1'b0;
      held_up     <= 1'b0;
      dir_right   <= 1'b0;
      dir_left    <= 1'b0;
      jump_pulse  <= 1'b0;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      evt_break   <= 1'b0;
      evt_ext     <= 1'b0;
      last_code   <= '0;
      err_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      last_h      <= last_h_n;
      held_right  <= hr_n;
      held_left   <= hl_n;
      held_up     <= hu_n;
      dir_right   <= dr_n;
      dir_left    <= dl_n;
      jump_pulse  <= jump_n;
      evt_valid   <= fire;
      err_timeout <= timeout;
      if (fire) begin
        evt_code  <= rx_data;
        evt_break <= fire_brk;
        evt_ext   <= fire_ext;
        last_code <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_ps2_arrow_key_tracker.sv
// Directed vector bench for ps2_arrow_key_tracker (REQUIRE_EXT=1 main DUT,
// REQUIRE_EXT=0 companion for the un-prefixed keypad path).
module tb_ps2_arrow_key_tracker;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;

  logic       held_right, held_left, held_up, dir_right, dir_left, jump_pulse;
  logic       evt_valid, evt_break, evt_ext, err_timeout;
  logic [7:0] evt_code, last_code;

  logic       u0_held_right, u0_held_left, u0_held_up, u0_dir_right, u0_dir_left;
  logic       u0_jump_pulse, u0_evt_valid, u0_evt_break, u0_evt_ext, u0_err_timeout;
  logic [7:0] u0_evt_code, u0_last_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_arrow_key_tracker #(.TIMEOUT_CYC(16), .REQUIRE_EXT(1'b1)) u_dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .held_right(held_right), .held_left(held_left), .held_up(held_up),
    .dir_right(dir_right), .dir_left(dir_left), .jump_pulse(jump_pulse),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_break(evt_break),
    .evt_ext(evt_ext), .last_code(last_code), .err_timeout(err_timeout)
  );

  ps2_arrow_key_tracker #(.TIMEOUT_CYC(16), .REQUIRE_EXT(1'b0)) u_dut0 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .held_right(u0_held_right), .held_left(u0_held_left),
    .held_up(u0_held_up), .dir_right(u0_dir_right), .dir_left(u0_dir_left),
    .jump_pulse(u0_jump_pulse), .evt_valid(u0_evt_valid), .evt_code(u0_evt_code),
    .evt_break(u0_evt_break), .evt_ext(u0_evt_ext), .last_code(u0_last_code),
    .err_timeout(u0_err_timeout)
  );

  // flags order: {evt_valid, evt_break, evt_ext, held_right, held_left, held_up, dir_right, dir_left, jump_pulse}
  typedef struct {
    logic [7:0] d;
    logic [8:0] flags;
    logic [7:0] code;
    logic [7:0] last;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic [7:0] d, input logic [8:0] f,
                             input logic [7:0] c, input logic [7:0] l);
    vec_t r;
    r.d = d; r.flags = f; r.code = c; r.last = l;
    return r;
  endfunction

  function automatic logic [8:0] flags_now();
    return {evt_valid, evt_break, evt_ext, held_right, held_left, held_up,
            dir_right, dir_left, jump_pulse};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_main(input string nm, input logic [8:0] f,
                            input logic [7:0] c, input logic [7:0] l);
    chk({nm, ".flags"}, 32'(flags_now()), 32'(f));
    chk({nm, ".code"},  32'(evt_code), 32'(c));
    chk({nm, ".last"},  32'(last_code), 32'(l));
    chk({nm, ".excl"},  32'(dir_right & dir_left), 32'(0));
  endtask

  int pulses, pulse_at;

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; clear = 1'b0; rx_data = 8'h00;

    vt.push_back(v(8'hE0, 9'b0_00_000_00_0, 8'h00, 8'h00));
    vt.push_back(v(8'h74, 9'b1_01_100_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_01_100_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_01_100_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'h74, 9'b1_11_000_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_11_000_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'h6B, 9'b1_01_010_01_0, 8'h6B, 8'h6B));
    vt.push_back(v(8'hE0, 9'b0_01_010_01_0, 8'h6B, 8'h6B));
    vt.push_back(v(8'h74, 9'b1_01_110_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_01_110_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_01_110_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'h74, 9'b1_11_010_01_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_11_010_01_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_11_010_01_0, 8'h74, 8'h74));
    vt.push_back(v(8'h6B, 9'b1_11_000_00_0, 8'h6B, 8'h6B));
    vt.push_back(v(8'hE0, 9'b0_11_000_00_0, 8'h6B, 8'h6B));
    vt.push_back(v(8'h75, 9'b1_01_001_00_1, 8'h75, 8'h75));
    for (int unsigned k = 0; k < 3; k++) begin
      vt.push_back(v(8'hE0, 9'b0_01_001_00_0, 8'h75, 8'h75));
      vt.push_back(v(8'h75, 9'b1_01_001_00_0, 8'h75, 8'h75));
    end
    vt.push_back(v(8'hAA, 9'b0_01_001_00_0, 8'h75, 8'h75));
    vt.push_back(v(8'hFA, 9'b0_01_001_00_0, 8'h75, 8'h75));
    vt.push_back(v(8'hFE, 9'b0_01_001_00_0, 8'h75, 8'h75));
    vt.push_back(v(8'h00, 9'b0_01_001_00_0, 8'h75, 8'h75));
    vt.push_back(v(8'h1C, 9'b1_00_001_00_0, 8'h1C, 8'h1C));
    vt.push_back(v(8'hF0, 9'b0_00_001_00_0, 8'h1C, 8'h1C));
    vt.push_back(v(8'hE0, 9'b0_00_001_00_0, 8'h1C, 8'h1C));
    vt.push_back(v(8'h74, 9'b1_01_101_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_01_101_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_01_101_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_01_101_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_01_101_10_0, 8'h74, 8'h74));
    vt.push_back(v(8'h74, 9'b1_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'hF0, 9'b0_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'hE0, 9'b0_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'h74, 9'b1_11_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'h74, 9'b1_00_001_00_0, 8'h74, 8'h74));
    vt.push_back(v(8'h6B, 9'b1_00_001_00_0, 8'h6B, 8'h6B));

    repeat (3) @(posedge CLOCK_50);
    #1;
    check_main("reset", 9'b0, 8'h00, 8'h00);
    chk("reset.err", 32'(err_timeout), 32'(0));
    chk("reset.u0", 32'({u0_held_right, u0_held_left, u0_held_up, u0_dir_right,
                         u0_dir_left, u0_jump_pulse, u0_evt_valid, u0_evt_break,
                         u0_evt_ext, u0_err_timeout, u0_evt_code, u0_last_code}), 32'(0));
    @(negedge CLOCK_50);
    resetn = 1'b1;

    foreach (vt[i]) begin
      send(vt[i].d);
      check_main($sformatf("vec%0d", i), vt[i].flags, vt[i].code, vt[i].last);
    end

    // Prefix abandoned: single err_timeout pulse 16 cycles after the E0
    send(8'hE0);
    pulses = 0; pulse_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (err_timeout) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("tmo.pulses", 32'(pulses), 32'(1));
    chk("tmo.cycle", 32'(pulse_at), 32'(16));
    send(8'h74);
    check_main("tmo.next74", 9'b1_00_001_00_0, 8'h74, 8'h74);

    // Byte on the expiry cycle is consumed, no timeout
    send(8'hE0);
    pulses = 0;
    repeat (15) begin
      @(posedge CLOCK_50);
      #1;
      if (err_timeout) pulses++;
    end
    send(8'hF0);
    if (err_timeout) pulses++;
    send(8'h75);
    if (err_timeout) pulses++;
    chk("edge.no_tmo", 32'(pulses), 32'(0));
    check_main("edge.brk75", 9'b1_11_000_00_0, 8'h75, 8'h75);

    // clear beats rx_valid in the same cycle
    send(8'hE0);
    send(8'h6B);
    check_main("clr.hold_l", 9'b1_01_010_01_0, 8'h6B, 8'h6B);
    send(8'hE0);
    @(negedge CLOCK_50);
    rx_data = 8'h74; rx_valid = 1'b1; clear = 1'b1;
    @(posedge CLOCK_50);
    #1;
    rx_valid = 1'b0; clear = 1'b0;
    check_main("clr.state", 9'b0, 8'h00, 8'h00);
    send(8'h74);
    check_main("clr.idle74", 9'b1_00_000_00_0, 8'h74, 8'h74);

    // Async reset in the middle of E0 F0, then 74 is a make from IDLE
    send(8'hE0);
    send(8'h74);
    check_main("rst.hold_r", 9'b1_01_100_10_0, 8'h74, 8'h74);
    send(8'hE0);
    send(8'hF0);
    @(negedge CLOCK_50);
    #3;
    resetn = 1'b0;
    #1;
    check_main("rst.async", 9'b0, 8'h00, 8'h00);
    chk("rst.u0_hr", 32'(u0_held_right), 32'(0));
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send(8'h74);
    check_main("rst.make74", 9'b1_00_000_00_0, 8'h74, 8'h74);
    chk("rst.u0_make", 32'({u0_evt_valid, u0_evt_break, u0_held_right, u0_dir_right}),
        32'(4'b1011));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
